// File: rtl/eb_credit_tx.sv
// eb_credit_tx: transmit end of a credit-based link.
// Upstream words arrive on a valid/ready target port and are staged in a
// two-slot elastic buffer. One word per cycle is launched towards the remote
// receiver as a ready-less valid pulse, but only while a credit is held.
// The receiver returns one credit pulse for every entry it frees.
// Every output is driven from registers only, so no combinational path
// runs from i_0_credit or t_0_valid to any output.
// Optional build macro: EB_CREDIT_TX_CHECK_EN
//   defined   - sticky err_credit flag on credit overflow, plus simulation
//               assertions on overflow and on upstream data stability.
//   undefined - err_credit tied low; credit saturation still applies.
module eb_credit_tx #(
    parameter int DW      = 32,
    parameter int CREDITS = 4,
    // Derived from CREDITS; not meant to be overridden.
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] t_0_data,
    input  logic          t_0_valid,
    output logic          t_0_ready,
    output logic [DW-1:0] i_0_data,
    output logic          i_0_valid,
    input  logic          i_0_credit,
    output logic [CW-1:0] credit_cnt,
    output logic          idle,
    output logic          err_credit
);

    localparam logic [CW-1:0] CREDITS_C = CW'(CREDITS);

    // Buffer occupancy (0..2) and the 1-bit slot pointers.
    logic [1:0]    r_cnt;
    logic          r_wptr;
    logic          r_rptr;
    // Credits currently held towards the remote receiver.
    logic [CW-1:0] r_credit_cnt;

    logic          w_push;
    logic          w_send;
    logic [1:0]    w_cnt_next;
    logic [CW-1:0] w_credit_next;
    logic [DW-1:0] w_head;

    // Ready only reflects registered occupancy: a send in the same cycle
    // does not free a slot early, which keeps the ready path register-only.
    assign t_0_ready = (r_cnt != 2'd2);
    assign w_push    = t_0_valid & t_0_ready;

    // A word leaves whenever one is buffered and a credit is held.
    assign w_send    = (r_cnt != 2'd0) & (r_credit_cnt != '0);

    // Data slots: one register per slot, written only when it is the target.
    // They carry no reset; the pointers and count decide what is valid.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            logic [DW-1:0] r_word;

            // Capture the incoming word into this slot on a push aimed at it.
            always_ff @(posedge clk) begin
                if (w_push && (r_wptr == 1'(gi))) begin
                    r_word <= t_0_data;
                end
            end
        end
    endgenerate

    assign w_head = r_rptr ? g_slot[1].r_word : g_slot[0].r_word;

    // Link outputs: head slot muxed from registers, forced to zero when no
    // word is being sent so the bus is quiet after reset and between words.
    assign i_0_valid  = w_send;
    assign i_0_data   = w_send ? w_head : '0;
    assign credit_cnt = r_credit_cnt;
    assign idle       = (r_cnt == 2'd0) & (r_credit_cnt == CREDITS_C);

    // Occupancy update: a simultaneous push and send leaves it unchanged.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_push && !w_send) begin
            w_cnt_next = r_cnt + 2'd1;
        end else if (!w_push && w_send) begin
            w_cnt_next = r_cnt - 2'd1;
        end
    end

    // Credit update: -1 per send, +1 per returned credit, saturating at
    // CREDITS so a spurious return can never inflate the count.
    always_comb begin
        w_credit_next = r_credit_cnt;
        if (w_send && !i_0_credit) begin
            w_credit_next = r_credit_cnt - CW'(1);
        end else if (!w_send && i_0_credit && (r_credit_cnt != CREDITS_C)) begin
            w_credit_next = r_credit_cnt + CW'(1);
        end
    end

    // Control state: reset discards buffered words and restores all credits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt        <= 2'd0;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_credit_cnt <= CREDITS_C;
        end else begin
            r_cnt        <= w_cnt_next;
            r_credit_cnt <= w_credit_next;
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_send) begin
                r_rptr <= ~r_rptr;
            end
        end
    end

`ifdef EB_CREDIT_TX_CHECK_EN
    // Overflow: a credit comes back while all credits are already home and
    // none is being spent this cycle.
    logic w_overflow;
    logic r_err_credit;

    assign w_overflow = i_0_credit & ~w_send & (r_credit_cnt == CREDITS_C);

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_credit <= 1'b0;
        end else if (w_overflow) begin
            r_err_credit <= 1'b1;
        end
    end

    assign err_credit = r_err_credit;

    // The receiver must never return more credits than it was given.
    a_no_credit_overflow: assert property (
        @(posedge clk) disable iff (!reset_n) !w_overflow
    );

    // A stalled upstream word must be held stable until accepted.
    a_src_data_stable: assert property (
        @(posedge clk) disable iff (!reset_n)
        (t_0_valid && !t_0_ready) |=> $stable(t_0_data)
    );
`else
    assign err_credit = 1'b0;
`endif

endmodule

// File: tb/tb_eb_credit_tx.sv
// tb_eb_credit_tx: self-checking bench for eb_credit_tx.
// A queue-based model of the buffer and an integer credit count predict the
// outputs; a negedge process compares them every cycle, and directed phases
// add hand-computed literal expectations.
`timescale 1ns/1ps
module tb_eb_credit_tx;

    localparam int DW      = 32;
    localparam int CREDITS = 4;
    localparam int CW      = $clog2(CREDITS + 1);
`ifdef EB_CREDIT_TX_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [DW-1:0] t_0_data;
    logic          t_0_valid;
    logic          t_0_ready;
    logic [DW-1:0] i_0_data;
    logic          i_0_valid;
    logic          i_0_credit;
    logic [CW-1:0] credit_cnt;
    logic          idle;
    logic          err_credit;

    always #5 clk = ~clk;

    eb_credit_tx #(.DW(DW), .CREDITS(CREDITS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .t_0_data   (t_0_data),
        .t_0_valid  (t_0_valid),
        .t_0_ready  (t_0_ready),
        .i_0_data   (i_0_data),
        .i_0_valid  (i_0_valid),
        .i_0_credit (i_0_credit),
        .credit_cnt (credit_cnt),
        .idle       (idle),
        .err_credit (err_credit)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state: words in the buffer, credits held, credits outstanding.
    logic [DW-1:0] m_q[$];
    int            m_cred = CREDITS;
    int            m_out = 0;
    bit            m_err = 1'b0;
    bit            m_send;
    bit            m_push;
    bit            m_ovf;
    // Stimulus helpers sampled at the clock edge.
    bit            acc_last = 1'b0;
    bit [1:0]      v_hist = 2'b00;
    logic [DW-1:0] rx_data[$];
    int            rx_cyc[$];
    int            cyc = 0;
    logic [DW-1:0] src_q[$];
    int            due_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Model update at each edge (or reset), from the transfer rules.
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_q.delete();
                m_cred   = CREDITS;
                m_out    = 0;
                m_err    = 1'b0;
                acc_last = 1'b0;
                v_hist   = 2'b00;
            end else begin
                m_send   = (m_q.size() > 0) && (m_cred > 0);
                m_push   = t_0_valid && (m_q.size() < 2);
                m_ovf    = i_0_credit && !m_send && (m_cred == CREDITS);
                acc_last = t_0_valid && t_0_ready;
                v_hist   = {v_hist[0], i_0_valid};
                if (i_0_valid) begin
                    rx_data.push_back(i_0_data);
                    rx_cyc.push_back(cyc);
                end
                if (m_send) void'(m_q.pop_front());
                if (m_push) m_q.push_back(t_0_data);
                m_cred = m_cred - int'(m_send) + int'(i_0_credit);
                if (m_cred > CREDITS) m_cred = CREDITS;
                m_out = m_out + int'(m_send) - int'(i_0_credit);
                if (m_out < 0) m_out = 0;
                if (m_ovf && ERR_EN) m_err = 1'b1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("t_0_ready", t_0_ready, 64'(m_q.size() < 2));
        chk("i_0_valid", i_0_valid, 64'((m_q.size() > 0) && (m_cred > 0)));
        if ((m_q.size() > 0) && (m_cred > 0)) chk("i_0_data", i_0_data, m_q[0]);
        chk("credit_cnt", credit_cnt, 64'(m_cred));
        chk("idle", idle, 64'((m_q.size() == 0) && (m_cred == CREDITS)));
        chk("err_credit", err_credit, 64'(m_err));
        if (reset_n) chk("credit_conservation", 64'(int'(credit_cnt) + m_out), 64'(CREDITS));
        if (i_0_valid) chk("valid_needs_credit", 64'(credit_cnt != '0), 64'd1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Valid/ready source: retire the accepted word, hold a stalled one,
    // otherwise present the next word when allowed.
    task automatic drive_src(input bit allow);
        if (acc_last) begin
            if (src_q.size() > 0) void'(src_q.pop_front());
            t_0_valid = 1'b0;
        end
        if ((src_q.size() > 0) && (t_0_valid || allow)) begin
            t_0_valid = 1'b1;
            t_0_data  = src_q[0];
        end else begin
            t_0_valid = 1'b0;
        end
    endtask

    // Remote receiver freeing each word after 1..8 cycles, one credit per cycle.
    task automatic drive_random_credit();
        if (v_hist[0]) due_q.push_back(cyc - 1 + int'($urandom_range(1, 8)));
        i_0_credit = 1'b0;
        for (int i = 0; i < due_q.size(); i++) begin
            if (due_q[i] <= cyc) begin
                due_q.delete(i);
                i_0_credit = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  p;
        int  rb;
        int  minc;
        bit  done;
        t_0_valid  = 1'b0;
        t_0_data   = '0;
        i_0_credit = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", t_0_ready, 1);
        chk("rst_valid", i_0_valid, 0);
        chk("rst_credit", credit_cnt, CREDITS);
        chk("rst_idle", idle, 1);
        chk("rst_err", err_credit, 0);
        chk("rst_data", i_0_data, 0);
        reset_n = 1'b1;

        // Six words, no credit return: four go out, two stay buffered.
        for (int i = 0; i < 6; i++) src_q.push_back(DW'(32'h10 + i));
        rb = rx_data.size();
        p  = cyc;
        drive_src(1'b1);
        repeat (8) begin
            tick();
            drive_src(1'b1);
            i_0_credit = 1'b0;
        end
        chk("t1_sent_count", rx_data.size() - rb, 4);
        for (int i = 0; i < 4; i++) begin
            if (rb + i < rx_data.size()) chk("t1_word", rx_data[rb + i], 32'h10 + i);
        end
        if (rx_data.size() - rb >= 4) begin
            chk("t1_first_cycle", rx_cyc[rb], p + 1);
            chk("t1_back_to_back", rx_cyc[rb + 3] - rx_cyc[rb], 3);
        end
        chk("t1_credit_zero", credit_cnt, 0);
        chk("t1_ready_full", t_0_ready, 0);
        chk("t1_valid_stalled", i_0_valid, 0);

        // One credit releases 0x14 on the next cycle, a second releases 0x15.
        tick(); i_0_credit = 1'b1;
        tick(); i_0_credit = 1'b0;
        chk("t2_valid_14", i_0_valid, 1);
        chk("t2_data_14", i_0_data, 32'h14);
        tick();
        chk("t2_credit_after_14", credit_cnt, 0);
        chk("t2_valid_after_14", i_0_valid, 0);
        tick(); i_0_credit = 1'b1;
        tick(); i_0_credit = 1'b0;
        chk("t2_valid_15", i_0_valid, 1);
        chk("t2_data_15", i_0_data, 32'h15);
        tick();
        chk("t2_ready_after_15", t_0_ready, 1);
        chk("t2_credit_after_15", credit_cnt, 0);
        chk("t2_idle_no_credit", idle, 0);
        repeat (4) begin tick(); i_0_credit = 1'b1; end
        tick(); i_0_credit = 1'b0;
        chk("t2_credits_home", credit_cnt, CREDITS);
        chk("t2_idle_home", idle, 1);

        // Stream 100 words, credit returned two cycles after each send.
        for (int i = 0; i < 100; i++) src_q.push_back(DW'(32'h100 + i));
        rb   = rx_data.size();
        minc = CREDITS;
        repeat (106) begin
            tick();
            drive_src(1'b1);
            i_0_credit = v_hist[1];
            if (int'(credit_cnt) < minc) minc = int'(credit_cnt);
        end
        i_0_credit = 1'b0;
        chk("t3_count", rx_data.size() - rb, 100);
        if (rx_data.size() - rb >= 100) begin
            chk("t3_no_gaps", rx_cyc[rb + 99] - rx_cyc[rb], 99);
            chk("t3_last_word", rx_data[rb + 99], 32'h163);
        end
        chk("t3_min_credit", minc, 2);
        chk("t3_idle_end", idle, 1);

        // Spurious credit while idle saturates.
        tick(); i_0_credit = 1'b1;
        tick(); i_0_credit = 1'b0;
        chk("t4_credit_saturated", credit_cnt, CREDITS);
        chk("t4_err_credit", err_credit, ERR_EN);

        // Reset with two words buffered and one credit held.
        for (int i = 0; i < 6; i++) src_q.push_back(DW'(32'h50 + i));
        repeat (10) begin
            tick();
            drive_src(1'b1);
            i_0_credit = 1'b0;
        end
        tick(); i_0_credit = 1'b1;
        tick(); i_0_credit = 1'b0;
        #1;
        chk("t5_pre_credit", credit_cnt, 1);
        chk("t5_pre_valid", i_0_valid, 1);
        chk("t5_pre_data", i_0_data, 32'h54);
        reset_n = 1'b0;
        src_q.delete();
        t_0_valid = 1'b0;
        #1;
        chk("t5_async_valid", i_0_valid, 0);
        chk("t5_async_ready", t_0_ready, 1);
        chk("t5_async_credit", credit_cnt, CREDITS);
        chk("t5_async_idle", idle, 1);
        chk("t5_async_data", i_0_data, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        rb = rx_data.size();
        repeat (6) begin tick(); i_0_credit = 1'b0; end
        chk("t5_no_stale", rx_data.size() - rb, 0);
        chk("t5_credit_after", credit_cnt, CREDITS);
        chk("t5_idle_after", idle, 1);

        // Random source and randomly delayed credit return.
        for (int i = 0; i < 80; i++) src_q.push_back(DW'(32'h1000 + i));
        due_q.delete();
        rb   = rx_data.size();
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            tick();
            drive_src(1'($urandom_range(0, 1)));
            drive_random_credit();
            if ((src_q.size() == 0) && !t_0_valid && (due_q.size() == 0) &&
                (rx_data.size() - rb == 80) && idle) done = 1'b1;
        end
        i_0_credit = 1'b0;
        chk("t6_completed", done, 1);
        chk("t6_count", rx_data.size() - rb, 80);
        if (rx_data.size() - rb >= 80) chk("t6_last_word", rx_data[rb + 79], 32'h104f);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
